// File: rtl/pipelined_adder.sv
// pipelined_adder: chunked ripple adder/subtractor with one carry register per stage and valid/ready flow control
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  localparam int CHUNK = WIDTH / STAGES;
  logic [STAGES-1:0] v_q, v_d, c_q, c_d;
  logic [STAGES:0]   ld;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [WIDTH-1:0]  r_d [STAGES];
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  src_a, src_b, src_r;
  logic              src_c;
  logic [CHUNK:0]    sum;
  // Ready ripples back from the consumer; each stage adds its chunk to the carry held by the stage before it
  always_comb begin
    ld = '0;
    ld[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) ld[k] = !v_q[k] || ld[k + 1];
    src_a = '0;
    src_b = '0;
    src_r = '0;
    src_c = 1'b0;
    sum = '0;
    v_d = '0;
    c_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      src_a = k == 0 ? ina : a_q[k == 0 ? 0 : k - 1];
      src_b = k == 0 ? (sub ? ~inb : inb) : b_q[k == 0 ? 0 : k - 1];
      src_c = k == 0 ? (sub ? ~cin : cin) : c_q[k == 0 ? 0 : k - 1];
      src_r = k == 0 ? '0 : r_q[k == 0 ? 0 : k - 1];
      sum = {1'b0, src_a[k*CHUNK +: CHUNK]} + {1'b0, src_b[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, src_c};
      a_d[k] = src_a;
      b_d[k] = src_b;
      r_d[k] = src_r;
      r_d[k][k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      c_d[k] = sum[CHUNK];
      v_d[k] = ld[k] ? (k == 0 ? in_valid : v_q[k == 0 ? 0 : k - 1]) : v_q[k];
    end
    ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (r_d[STAGES-1][WIDTH-1] != src_a[WIDTH-1]);
  end
  // A stage captures new contents only when it loads, so a stalled pipeline holds everything in place
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (!rst_n) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
      end else if (ld[k]) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        r_q[k] <= r_d[k];
        c_q[k] <= c_d[k];
      end
    end
    v_q <= rst_n ? v_d : '0;
    ovf_q <= !rst_n ? 1'b0 : ld[STAGES-1] ? ovf_d : ovf_q;
  end
  assign in_ready  = ld[0];
  assign out_valid = v_q[STAGES-1];
  assign result    = r_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of three pipelined_adder builds against an arithmetic model
module tb_pipelined_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n;
  logic        in_valid [3];
  logic        in_ready [3];
  logic        cin [3];
  logic        sub [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        cout [3];
  logic        overflow [3];
  logic [15:0] ina [3];
  logic [15:0] inb [3];
  logic [15:0] result [3];
  int st [3] = '{4, 1, 16};
  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic [17:0] exp_m [3][2048];
  logic [17:0] got_m [3][2048];
  int acc_cyc [3][2048];
  int out_cyc [3][2048];
  int n_acc [3];
  int n_out [3];
  int max_occ [3];

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .ina(ina[0]), .inb(inb[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .cout(cout[0]), .overflow(overflow[0]));
  pipelined_adder #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .ina(ina[1]), .inb(inb[1]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .cout(cout[1]), .overflow(overflow[1]));
  pipelined_adder #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .ina(ina[2]), .inb(inb[2]), .cin(cin[2]), .sub(sub[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .result(result[2]), .cout(cout[2]), .overflow(overflow[2]));

  // Reference: plain integer arithmetic, signed range test for overflow, returns {overflow, cout, result}
  function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    int ua, ub, sa, sb, u, sv;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = $signed(a);
    sb = $signed(b);
    u  = s ? ua - ub - int'(c) : ua + ub + int'(c);
    sv = s ? sa - sb - int'(c) : sa + sb + int'(c);
    co = s ? (u >= 0) : (u > 65535);
    ov = (sv > 32767) || (sv < -32768);
    return {ov, co, u[15:0]};
  endfunction

  function automatic logic [15:0] rnd16();
    int p;
    p = $urandom_range(0, 7);
    return p == 0 ? 16'h0000 : p == 1 ? 16'hFFFF : p == 2 ? 16'h7FFF : p == 3 ? 16'h8000 : 16'($urandom);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Records accepted operand sets (with model results) and consumed outputs per instance
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        n_acc[d] <= 0;
        n_out[d] <= 0;
        max_occ[d] <= 0;
      end else begin
        if (n_acc[d] - n_out[d] > max_occ[d]) max_occ[d] <= n_acc[d] - n_out[d];
        if (in_valid[d] && in_ready[d] && n_acc[d] < 2048) begin
          exp_m[d][n_acc[d]] <= ref_model(ina[d], inb[d], cin[d], sub[d]);
          acc_cyc[d][n_acc[d]] <= cyc;
          n_acc[d] <= n_acc[d] + 1;
        end
        if (out_valid[d] && out_ready[d] && n_out[d] < 2048) begin
          got_m[d][n_out[d]] <= {overflow[d], cout[d], result[d]};
          out_cyc[d][n_out[d]] <= cyc;
          n_out[d] <= n_out[d] + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
    end
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input int d, input logic [15:0] a, input logic [15:0] b, input logic c, input logic s, output bit ok);
    ina[d] = a;
    inb[d] = b;
    cin[d] = c;
    sub[d] = s;
    in_valid[d] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready[d];
      step();
    end
    in_valid[d] = 1'b0;
    cin[d] = ~c;
    sub[d] = ~s;
  endtask

  task automatic wait_out(input int d, input int target, input int budget);
    for (int i = 0; i < budget && n_out[d] < target; i++) step();
  endtask

  task automatic test_reset();
    do_reset(2);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (out_valid[d] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid[d]);
      else passed++;
      total++;
      if ({overflow[d], cout[d], result[d]} !== 18'h0)
        $display("FAIL reset_data[%0d]: got ovf=%b cout=%b result=%h want all 0", d, overflow[d], cout[d], result[d]);
      else passed++;
      total++;
      if (in_ready[d] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready[d]);
      else passed++;
    end
    step();
  endtask

  task automatic test_corners();
    logic [15:0] ta [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0005};
    logic [15:0] tbv [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0007};
    logic        tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] tr [4] = '{16'h0000, 16'h8000, 16'hFFFE, 16'hFFFD};
    logic        tco [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        tov [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit ok;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      send(0, ta[i], tbv[i], tc[i], ts[i], ok);
      total++;
      if (!ok) $display("FAIL corner%0d_accept: in_ready stayed 0, want 1", i);
      else passed++;
      wait_out(0, i + 1, 20);
      total++;
      if (n_out[0] !== i + 1) $display("FAIL corner%0d_count: got %0d outputs want %0d", i, n_out[0], i + 1);
      else passed++;
      total++;
      if (got_m[0][i][15:0] !== tr[i]) $display("FAIL corner%0d_result: got %h want %h", i, got_m[0][i][15:0], tr[i]);
      else passed++;
      total++;
      if (got_m[0][i][16] !== tco[i]) $display("FAIL corner%0d_cout: got %b want %b", i, got_m[0][i][16], tco[i]);
      else passed++;
      total++;
      if (got_m[0][i][17] !== tov[i]) $display("FAIL corner%0d_overflow: got %b want %b", i, got_m[0][i][17], tov[i]);
      else passed++;
      total++;
      if (out_cyc[0][i] - acc_cyc[0][i] !== 4)
        $display("FAIL corner%0d_latency: got %0d cycles want 4", i, out_cyc[0][i] - acc_cyc[0][i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a8 [8];
    logic [15:0] b8 [8];
    logic        c8 [8];
    logic        s8 [8];
    logic [17:0] held;
    int j;
    for (int i = 0; i < 8; i++) begin
      a8[i] = rnd16();
      b8[i] = rnd16();
      c8[i] = 1'($urandom);
      s8[i] = 1'($urandom);
    end
    do_reset(1);
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 20 && n_acc[0] < 4; i++) begin
      j = n_acc[0];
      ina[0] = a8[j];
      inb[0] = b8[j];
      cin[0] = c8[j];
      sub[0] = s8[j];
      step();
      out_ready[0] = 1'b0;
    end
    ina[0] = a8[4];
    inb[0] = b8[4];
    cin[0] = c8[4];
    sub[0] = s8[4];
    @(negedge clk);
    total++;
    if (in_ready[0] !== 1'b0) $display("FAIL b2b_full_in_ready: got %b want 0 with %0d held", in_ready[0], n_acc[0]);
    else passed++;
    total++;
    if (out_valid[0] !== 1'b1) $display("FAIL b2b_full_out_valid: got %b want 1", out_valid[0]);
    else passed++;
    held = {overflow[0], cout[0], result[0]};
    step();
    step();
    step();
    @(negedge clk);
    total++;
    if (n_acc[0] !== 4 || n_out[0] !== 0)
      $display("FAIL b2b_stall_counts: got acc=%0d out=%0d want acc=4 out=0", n_acc[0], n_out[0]);
    else passed++;
    total++;
    if ({overflow[0], cout[0], result[0]} !== held || held !== ref_model(a8[0], b8[0], c8[0], s8[0]))
      $display("FAIL b2b_stall_hold: got %h held %h want %h", {overflow[0], cout[0], result[0]}, held, ref_model(a8[0], b8[0], c8[0], s8[0]));
    else passed++;
    step();
    out_ready[0] = 1'b1;
    for (int i = 0; i < 60 && n_out[0] < 8; i++) begin
      j = n_acc[0] < 8 ? n_acc[0] : 7;
      in_valid[0] = n_acc[0] < 8;
      ina[0] = a8[j];
      inb[0] = b8[j];
      cin[0] = c8[j];
      sub[0] = s8[j];
      step();
    end
    in_valid[0] = 1'b0;
    total++;
    if (n_out[0] !== 8) $display("FAIL b2b_drain_count: got %0d outputs want 8", n_out[0]);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got_m[0][i] !== ref_model(a8[i], b8[i], c8[i], s8[i]))
        $display("FAIL b2b_result%0d: got %h want %h", i, got_m[0][i], ref_model(a8[i], b8[i], c8[i], s8[i]));
      else passed++;
    end
  endtask

  task automatic test_reset_flush();
    logic [15:0] a, b;
    logic c, s;
    bit ok;
    do_reset(1);
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ina[0] = rnd16();
      inb[0] = rnd16();
      cin[0] = 1'($urandom);
      sub[0] = 1'($urandom);
      step();
    end
    in_valid[0] = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid[0] !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid[0]);
    else passed++;
    total++;
    if (in_ready[0] !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", in_ready[0]);
    else passed++;
    repeat (8) step();
    total++;
    if (n_out[0] !== 0) $display("FAIL flush_no_stale: got %0d outputs want 0", n_out[0]);
    else passed++;
    a = rnd16();
    b = rnd16();
    c = 1'($urandom);
    s = 1'($urandom);
    send(0, a, b, c, s, ok);
    wait_out(0, 1, 20);
    repeat (6) step();
    total++;
    if (!ok || n_out[0] !== 1) $display("FAIL flush_new_count: got %0d outputs want 1", n_out[0]);
    else passed++;
    total++;
    if (got_m[0][0] !== ref_model(a, b, c, s)) $display("FAIL flush_new_result: got %h want %h", got_m[0][0], ref_model(a, b, c, s));
    else passed++;
    total++;
    if (out_cyc[0][0] - acc_cyc[0][0] !== 4)
      $display("FAIL flush_new_latency: got %0d cycles want 4", out_cyc[0][0] - acc_cyc[0][0]);
    else passed++;
  endtask

  task automatic test_random(input int d);
    logic        stall;
    logic [17:0] held;
    do_reset(1);
    for (int i = 0; i < 20000 && n_out[d] < 1000; i++) begin
      in_valid[d] = n_acc[d] < 1000 && $urandom_range(0, 3) != 0;
      ina[d] = rnd16();
      inb[d] = rnd16();
      cin[d] = 1'($urandom);
      sub[d] = 1'($urandom);
      out_ready[d] = $urandom_range(0, 3) != 0;
      @(negedge clk);
      stall = out_valid[d] && !out_ready[d];
      held = {overflow[d], cout[d], result[d]};
      step();
      if (stall) begin
        total++;
        if (out_valid[d] !== 1'b1 || {overflow[d], cout[d], result[d]} !== held)
          $display("FAIL rand%0d_stall_hold: got v=%b %h want v=1 %h", st[d], out_valid[d], {overflow[d], cout[d], result[d]}, held);
        else passed++;
      end
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    total++;
    if (n_out[d] !== 1000) $display("FAIL rand%0d_count: got %0d outputs want 1000", st[d], n_out[d]);
    else passed++;
    total++;
    if (max_occ[d] > st[d]) $display("FAIL rand%0d_occupancy: got %0d in flight want <= %0d", st[d], max_occ[d], st[d]);
    else passed++;
    for (int i = 0; i < 1000; i++) begin
      total++;
      if (got_m[d][i] !== exp_m[d][i]) $display("FAIL rand%0d_result%0d: got %h want %h", st[d], i, got_m[d][i], exp_m[d][i]);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
      ina[d] = '0;
      inb[d] = '0;
      cin[d] = 1'b0;
      sub[d] = 1'b0;
    end
    test_reset();
    test_corners();
    test_back_to_back();
    test_reset_flush();
    test_random(1);
    test_random(2);
    test_random(0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
